tile_clk_rst_sequencer: RTL and testbench
=========================================

// Module: tile_clk_rst_sequencer
// PURPOSE
// - Sequences clock-enable, reset and NoC isolation for the mesh tiles (clusters, memory tiles, SPU).
// - Driven by per-tile enable bits from the chip control register file.
// - One shared FSM services one tile at a time, limiting inrush and enforcing a safe order:
//   - power-up: clk on -> hold -> rst release + iso release
//   - power-down: iso req -> ack -> rst assert -> hold -> clk off
// - Outputs feed each tile's tile_clk_en_i / tile_rst_ni and the NoC isolation handshake.
// PARAMETERS
// - NumTiles       16    number of sequenced tiles (>=1)
// - RstHoldCycles   8    cycles reset is held around clock enable/gate (>=1)
// - TimeoutCycles 1024   isolation-ack timeout; used only with TILE_SEQ_TIMEOUT_EN
// PORTS
// - clk_i          in   1         clock
// - rst_i          in   1         asynchronous reset, active-high
// - test_mode_i    in   1         1: force all tile_clk_en_o=1, tile_rst_no=1, iso_req_o=0 (comb override)
// - cfg_en_i       in   NumTiles  target state per tile (1=on); level, may change any cycle
// - iso_ack_i      in   NumTiles  tile reports NoC traffic drained/isolated
// - tile_clk_en_o  out  NumTiles  per-tile clock enable
// - tile_rst_no    out  NumTiles  per-tile reset toward tile, active-low
// - iso_req_o      out  NumTiles  per-tile isolation request
// - tile_on_o      out  NumTiles  status: tile fully up
// - busy_o         out  1         FSM not IDLE
// - err_o          out  NumTiles  sticky timeout flag (0 when macro absent)
// BEHAVIOUR
// - Reset values (all outputs registered): tile_clk_en_o=0, tile_rst_no=0, iso_req_o='1, tile_on_o=0, busy_o=0, err_o=0.
// - Async rst_i mid-sequence returns all outputs and FSM to reset values immediately.
// - Mismatch per tile: cfg_en_i[t] != tile_on_o[t].
// - Arbitration in IDLE:
//   - round-robin; pick lowest mismatched t >= ptr, wrapping; latch idx; ptr <= idx+1 (mod NumTiles).
// - Power-up (cfg_en_i[t]=1):
//   - IDLE: detect; next cycle tile_clk_en_o[t]=1; state UP_HOLD; counter=0.
//   - UP_HOLD: count RstHoldCycles cycles; on final count, next cycle tile_rst_no[t]=1, iso_req_o[t]=0, tile_on_o[t]=1; state IDLE.
//   - Latency: detect -> clk_en 1 cycle; clk_en -> rst release exactly RstHoldCycles cycles.
// - Power-down (cfg_en_i[t]=0):
//   - IDLE: detect; next cycle iso_req_o[t]=1; state ISO_WAIT.
//   - ISO_WAIT: on iso_ack_i[t]=1, next cycle tile_rst_no[t]=0; state DN_HOLD; counter=0.
//   - DN_HOLD: after RstHoldCycles cycles, next cycle tile_clk_en_o[t]=0, tile_on_o[t]=0; state IDLE.
// - Other tiles' outputs never change while one tile is in service.
// - cfg_en_i toggling for the in-service tile is ignored until its sequence completes; re-evaluated in IDLE (one IDLE cycle minimum between sequences).
// - iso_ack_i already high on entry to ISO_WAIT: proceeds next cycle (no edge required).
// - iso_ack_i of non-selected tiles ignored.
// - Counter width $clog2(max(RstHoldCycles,TimeoutCycles)+1); no wrap, saturates at terminal count.
// - Invariants (assert in RTL):
//   - tile_rst_no[t] -> tile_clk_en_o[t]
//   - tile_on_o[t] == tile_rst_no[t]
//   - RstHoldCycles >= 1
// CONFIGURATION
// - TILE_SEQ_TIMEOUT_EN defined:
//   - ISO_WAIT counts cycles; at TimeoutCycles without ack, set err_o[t] sticky and proceed to DN_HOLD as if acked.
//   - err_o[t] is cleared only by rst_i.
// - TILE_SEQ_TIMEOUT_EN undefined:
//   - ISO_WAIT waits indefinitely; err_o tied 0; no timeout counter logic.
// TESTING
// - Reset, cfg_en_i=16'h0003, RstHoldCycles=8:
//   - tile0 clk_en rises at cycle 1; rst_no/tile_on rise at cycle 9.
//   - tile1 starts in the following IDLE cycle, and only then.
// - Tile2 on, then cfg_en_i[2]=0, iso_ack_i[2] held 0 for 20 cycles then 1:
//   - rst_no[2] falls 1 cycle after ack; clk_en[2] falls 8 cycles later.
// - Simultaneous mismatch on tiles 3,7,15 with ptr=8:
//   - service order 15,3,7.
// - Toggle cfg_en_i[4] 1->0 during UP_HOLD:
//   - power-up completes (tile_on=1), then power-down sequence runs.
// - TILE_SEQ_TIMEOUT_EN, TimeoutCycles=1024, ack never given:
//   - err_o[5]=1 after 1024 cycles in ISO_WAIT; tile5 gated 8 cycles later.
//   - Without macro: busy_o stays 1.
// - Assert rst_i mid-UP_HOLD:
//   - all outputs return to reset values the same cycle.
//   - after release, sequencing restarts from tile 0.
// - test_mode_i=1 at any point:
//   - all clk_en=1, rst_no=1, iso_req=0.

Source files
------------

// File: rtl/tile_clk_rst_sequencer_if.sv
// ---------------------------------------------------------------------------
// tile_clk_rst_sequencer_if
// Purpose : bundles the control inputs and per-tile outputs of the tile
//           clock/reset/isolation sequencer into one interface.
// Signals : test_mode_i - force all tiles on (clock enabled, out of reset,
//                         not isolated)
//           cfg_en_i    - target on/off state per tile
//           iso_ack_i   - per-tile NoC drained/isolated acknowledge
//           tile_clk_en_o, tile_rst_no, iso_req_o - per-tile controls
//           tile_on_o   - per-tile "fully up" status
//           busy_o      - sequencer is servicing a tile
//           err_o       - per-tile sticky isolation timeout flag
// Modports: master - the sequencer (drives the tile controls)
//           slave  - the control side (drives cfg/ack/test_mode)
// ---------------------------------------------------------------------------
interface tile_clk_rst_sequencer_if #(
    parameter int NumTiles = 16
) ();
    logic                test_mode_i;
    logic [NumTiles-1:0] cfg_en_i;
    logic [NumTiles-1:0] iso_ack_i;
    logic [NumTiles-1:0] tile_clk_en_o;
    logic [NumTiles-1:0] tile_rst_no;
    logic [NumTiles-1:0] iso_req_o;
    logic [NumTiles-1:0] tile_on_o;
    logic                busy_o;
    logic [NumTiles-1:0] err_o;

    modport master (
        input  test_mode_i, cfg_en_i, iso_ack_i,
        output tile_clk_en_o, tile_rst_no, iso_req_o, tile_on_o, busy_o, err_o
    );

    modport slave (
        output test_mode_i, cfg_en_i, iso_ack_i,
        input  tile_clk_en_o, tile_rst_no, iso_req_o, tile_on_o, busy_o, err_o
    );
endinterface

// File: rtl/tile_clk_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tile_clk_rst_sequencer
// Purpose : one shared FSM that powers mesh tiles up and down one at a time.
//           Power-up  : clock enable -> RstHoldCycles -> reset/iso release.
//           Power-down: iso request -> ack -> reset assert -> RstHoldCycles
//                       -> clock gate.
//           Tiles are picked round-robin among those whose cfg_en_i differs
//           from tile_on_o.
// Ports   : clk_i, rst_i (async, active-high), bus (master modport of
//           tile_clk_rst_sequencer_if).
// Config  : TILE_SEQ_TIMEOUT_EN - when defined, ISO_WAIT gives up after
//           TimeoutCycles without ack, sets err_o[t] (sticky) and proceeds
//           as if acked. When undefined, ISO_WAIT waits forever, err_o=0.
// Note    : tile_on_o tracks tile_rst_no, so a tile stops reporting "on" as
//           soon as its reset is asserted during power-down.
// ---------------------------------------------------------------------------

// Invariant checker for the registered (pre test-mode override) tile controls.
module tile_clk_rst_sequencer_chk #(
    parameter int NumTiles      = 16,
    parameter int RstHoldCycles = 8
) (
    input logic                clk_i,
    input logic                rst_i,
    input logic [NumTiles-1:0] clk_en_q,
    input logic [NumTiles-1:0] rst_n_q,
    input logic [NumTiles-1:0] tile_on_q
);
    a_hold_min : assert property (@(posedge clk_i) RstHoldCycles >= 1);

    a_rst_needs_clk : assert property (@(posedge clk_i) disable iff (rst_i)
        ((rst_n_q & ~clk_en_q) == {NumTiles{1'b0}}));

    a_on_eq_rst : assert property (@(posedge clk_i) disable iff (rst_i)
        (tile_on_q == rst_n_q));
endmodule

module tile_clk_rst_sequencer #(
    parameter int NumTiles      = 16,
    parameter int RstHoldCycles = 8,
    parameter int TimeoutCycles = 1024
) (
    input logic                          clk_i,
    input logic                          rst_i,
    tile_clk_rst_sequencer_if.master     bus
);
    localparam int IdxW    = (NumTiles > 1) ? $clog2(NumTiles) : 1;
    localparam int CntMaxV = (RstHoldCycles > TimeoutCycles) ? RstHoldCycles : TimeoutCycles;
    localparam int CntW    = $clog2(CntMaxV + 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(RstHoldCycles - 1);
`ifdef TILE_SEQ_TIMEOUT_EN
    localparam logic [CntW-1:0] TmoLast  = CntW'(TimeoutCycles - 1);
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UP_HOLD  = 2'd1,
        ISO_WAIT = 2'd2,
        DN_HOLD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NumTiles-1:0] clk_en_q, clk_en_d;
    logic [NumTiles-1:0] rst_n_q, rst_n_d;
    logic [NumTiles-1:0] iso_req_q, iso_req_d;
    logic [NumTiles-1:0] tile_on_q, tile_on_d;
    logic                busy_q;

    logic [NumTiles-1:0] mis_s;
    logic                found_s;
    logic [IdxW-1:0]     sel_s;
    logic [IdxW-1:0]     sel_nxt_s;
    logic [IdxW-1:0]     cand_s;
    int                  cand_i;
    int                  nxt_i;
    logic                up_done_s;
    logic                dn_done_s;
    logic                ack_sel_s;
    logic                tmo_s;
    logic                iso_go_s;

    assign mis_s     = bus.cfg_en_i ^ tile_on_q;
    assign up_done_s = (state_q == UP_HOLD) && (cnt_q == HoldLast);
    assign dn_done_s = (state_q == DN_HOLD) && (cnt_q == HoldLast);
    assign ack_sel_s = bus.iso_ack_i[idx_q];
`ifdef TILE_SEQ_TIMEOUT_EN
    assign tmo_s     = (state_q == ISO_WAIT) && !ack_sel_s && (cnt_q == TmoLast);
`else
    assign tmo_s     = 1'b0;
`endif
    assign iso_go_s  = (state_q == ISO_WAIT) && (ack_sel_s || tmo_s);

    // Round-robin pick: scan from ptr downward in priority so the lowest offset wins.
    always_comb begin
        found_s   = 1'b0;
        sel_s     = {IdxW{1'b0}};
        cand_i    = 0;
        cand_s    = {IdxW{1'b0}};
        for (int i = NumTiles - 1; i >= 0; i--) begin
            cand_i  = int'(ptr_q) + i;
            cand_i  = (cand_i >= NumTiles) ? (cand_i - NumTiles) : cand_i;
            cand_s  = IdxW'(cand_i);
            sel_s   = mis_s[cand_s] ? cand_s : sel_s;
            found_s = found_s | mis_s[cand_s];
        end
        nxt_i     = int'(sel_s) + 1;
        sel_nxt_s = (nxt_i >= NumTiles) ? {IdxW{1'b0}} : IdxW'(nxt_i);
    end

    // Next-state, selected index, pointer and shared hold/timeout counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    idx_d   = sel_s;
                    ptr_d   = sel_nxt_s;
                    cnt_d   = {CntW{1'b0}};
                    state_d = bus.cfg_en_i[sel_s] ? UP_HOLD : ISO_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            UP_HOLD, DN_HOLD: begin
                if (cnt_q == HoldLast) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
                end
            end
            ISO_WAIT: begin
                if (iso_go_s) begin
                    state_d = DN_HOLD;
                    cnt_d   = {CntW{1'b0}};
                end else begin
`ifdef TILE_SEQ_TIMEOUT_EN
                    cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
`else
                    cnt_d = cnt_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the per-tile controls; only the selected tile ever changes.
    always_comb begin
        clk_en_d  = clk_en_q;
        rst_n_d   = rst_n_q;
        iso_req_d = iso_req_q;
        tile_on_d = tile_on_q;
        case (state_q)
            IDLE: begin
                if (found_s && bus.cfg_en_i[sel_s]) begin
                    clk_en_d[sel_s] = 1'b1;
                end else if (found_s) begin
                    iso_req_d[sel_s] = 1'b1;
                end else begin
                    clk_en_d = clk_en_q;
                end
            end
            UP_HOLD: begin
                if (up_done_s) begin
                    rst_n_d[idx_q]   = 1'b1;
                    tile_on_d[idx_q] = 1'b1;
                    iso_req_d[idx_q] = 1'b0;
                end else begin
                    rst_n_d = rst_n_q;
                end
            end
            ISO_WAIT: begin
                if (iso_go_s) begin
                    rst_n_d[idx_q]   = 1'b0;
                    tile_on_d[idx_q] = 1'b0;
                end else begin
                    rst_n_d = rst_n_q;
                end
            end
            DN_HOLD: begin
                if (dn_done_s) begin
                    clk_en_d[idx_q] = 1'b0;
                end else begin
                    clk_en_d = clk_en_q;
                end
            end
            default: begin
                clk_en_d = clk_en_q;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= {IdxW{1'b0}};
            ptr_q     <= {IdxW{1'b0}};
            cnt_q     <= {CntW{1'b0}};
            clk_en_q  <= {NumTiles{1'b0}};
            rst_n_q   <= {NumTiles{1'b0}};
            iso_req_q <= {NumTiles{1'b1}};
            tile_on_q <= {NumTiles{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            clk_en_q  <= clk_en_d;
            rst_n_q   <= rst_n_d;
            iso_req_q <= iso_req_d;
            tile_on_q <= tile_on_d;
            busy_q    <= (state_d != IDLE);
        end
    end

`ifdef TILE_SEQ_TIMEOUT_EN
    logic [NumTiles-1:0] err_q;

    // Sticky timeout flags, cleared only by rst_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= {NumTiles{1'b0}};
        end else if (tmo_s) begin
            err_q[idx_q] <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = {NumTiles{1'b0}};
`endif

    // Test mode overrides the tile controls combinationally.
    assign bus.tile_clk_en_o = bus.test_mode_i ? {NumTiles{1'b1}} : clk_en_q;
    assign bus.tile_rst_no   = bus.test_mode_i ? {NumTiles{1'b1}} : rst_n_q;
    assign bus.iso_req_o     = bus.test_mode_i ? {NumTiles{1'b0}} : iso_req_q;
    assign bus.tile_on_o     = tile_on_q;
    assign bus.busy_o        = busy_q;

    tile_clk_rst_sequencer_chk #(
        .NumTiles      (NumTiles),
        .RstHoldCycles (RstHoldCycles)
    ) u_chk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clk_en_q  (clk_en_q),
        .rst_n_q   (rst_n_q),
        .tile_on_q (tile_on_q)
    );
endmodule

// File: tb/tb_tile_clk_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tile_clk_rst_sequencer
// Directed bench for tile_clk_rst_sequencer (NumTiles=16, RstHoldCycles=8,
// TimeoutCycles=1024). Inputs change and outputs are sampled 1ns after the
// rising clock edge.
// ---------------------------------------------------------------------------
module tb_tile_clk_rst_sequencer;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [15:0] cfg;

    tile_clk_rst_sequencer_if #(.NumTiles(16)) bus ();

    tile_clk_rst_sequencer #(
        .NumTiles      (16),
        .RstHoldCycles (8),
        .TimeoutCycles (1024)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] v);
        cfg = v;
        bus.cfg_en_i = v;
    endtask

    // Wait until idle with every tile at its target, then check the steady state.
    task automatic wait_settle(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(bus.busy_o == 1'b0 && bus.tile_on_o == cfg)) begin
            step(1);
            n++;
        end
        check_eq({tag, "_settle_timeout"}, {31'd0, (n >= budget)}, 32'd0);
        check_eq({tag, "_clk_en"},  {16'd0, bus.tile_clk_en_o}, {16'd0, cfg});
        check_eq({tag, "_rst_n"},   {16'd0, bus.tile_rst_no},   {16'd0, cfg});
        check_eq({tag, "_iso_req"}, {16'd0, bus.iso_req_o},     {16'd0, ~cfg});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        bus.test_mode_i = 1'b0;
        bus.iso_ack_i   = 16'h0000;
        set_cfg(16'h0003);
        step(2);

        // Reset values
        check_eq("rst_clk_en",  {16'd0, bus.tile_clk_en_o}, 32'h0000);
        check_eq("rst_rst_n",   {16'd0, bus.tile_rst_no},   32'h0000);
        check_eq("rst_iso_req", {16'd0, bus.iso_req_o},     32'hFFFF);
        check_eq("rst_tile_on", {16'd0, bus.tile_on_o},     32'h0000);
        check_eq("rst_busy",    {31'd0, bus.busy_o},        32'd0);
        check_eq("rst_err",     {16'd0, bus.err_o},         32'h0000);

        // Power-up of tiles 0 and 1 after reset
        rst = 1'b0;
        step(1);
        check_eq("t0_clk_en_c1", {16'd0, bus.tile_clk_en_o}, 32'h0001);
        check_eq("t0_rst_n_c1",  {31'd0, bus.tile_rst_no[0]}, 32'd0);
        check_eq("t0_busy_c1",   {31'd0, bus.busy_o},         32'd1);
        step(7);
        check_eq("t0_rst_n_c8",  {31'd0, bus.tile_rst_no[0]}, 32'd0);
        step(1);
        check_eq("t0_rst_n_c9",  {31'd0, bus.tile_rst_no[0]}, 32'd1);
        check_eq("t0_on_c9",     {31'd0, bus.tile_on_o[0]},   32'd1);
        check_eq("t0_iso_c9",    {31'd0, bus.iso_req_o[0]},   32'd0);
        check_eq("t1_clk_en_c9", {31'd0, bus.tile_clk_en_o[1]}, 32'd0);
        check_eq("busy_idle_c9", {31'd0, bus.busy_o},         32'd0);
        step(1);
        check_eq("t1_clk_en_c10", {31'd0, bus.tile_clk_en_o[1]}, 32'd1);
        wait_settle("t01", 100);

        // Tile 2 up, then down with a late ack
        set_cfg(16'h0007);
        wait_settle("t2up", 100);
        set_cfg(16'h0003);
        step(1);
        check_eq("t2_iso_req", {31'd0, bus.iso_req_o[2]},   32'd1);
        check_eq("t2_rst_n_a", {31'd0, bus.tile_rst_no[2]}, 32'd1);
        step(20);
        check_eq("t2_wait_rst_n", {31'd0, bus.tile_rst_no[2]}, 32'd1);
        check_eq("t2_wait_busy",  {31'd0, bus.busy_o},         32'd1);
        bus.iso_ack_i = 16'h0004;
        step(1);
        check_eq("t2_rst_n_fall", {31'd0, bus.tile_rst_no[2]},   32'd0);
        check_eq("t2_on_fall",    {31'd0, bus.tile_on_o[2]},     32'd0);
        check_eq("t2_clk_hold",   {31'd0, bus.tile_clk_en_o[2]}, 32'd1);
        check_eq("t2_others",     {16'd0, bus.tile_clk_en_o},    32'h0007);
        step(7);
        check_eq("t2_clk_h7",     {31'd0, bus.tile_clk_en_o[2]}, 32'd1);
        step(1);
        check_eq("t2_clk_off",    {31'd0, bus.tile_clk_en_o[2]}, 32'd0);
        bus.iso_ack_i = 16'h0000;
        wait_settle("t2dn", 100);

        // Tile 7 up leaves ptr at 8; then mismatch on 3,7,15 -> order 15,3,7
        set_cfg(16'h0083);
        wait_settle("t7up", 100);
        bus.iso_ack_i = 16'h0080;
        set_cfg(16'h800B);
        step(1);
        check_eq("rr_first15", {16'd0, bus.tile_clk_en_o & 16'h8008}, 32'h8000);
        check_eq("rr_t7_idle", {31'd0, bus.iso_req_o[7]},             32'd0);
        step(8);
        check_eq("rr_t15_up",  {31'd0, bus.tile_rst_no[15]},   32'd1);
        check_eq("rr_t3_wait", {31'd0, bus.tile_clk_en_o[3]},  32'd0);
        step(1);
        check_eq("rr_second3", {31'd0, bus.tile_clk_en_o[3]},  32'd1);
        check_eq("rr_t7_wait", {31'd0, bus.iso_req_o[7]},      32'd0);
        step(9);
        check_eq("rr_third7",  {31'd0, bus.iso_req_o[7]},      32'd1);
        step(1);
        check_eq("rr_t7_preack", {31'd0, bus.tile_rst_no[7]},  32'd0);
        bus.iso_ack_i = 16'h0000;
        wait_settle("rr", 100);

        // Toggle cfg_en[4] during UP_HOLD: power-up completes, then power-down
        set_cfg(cfg | 16'h0010);
        step(1);
        check_eq("t4_clk_en", {31'd0, bus.tile_clk_en_o[4]}, 32'd1);
        step(3);
        set_cfg(cfg & ~16'h0010);
        step(5);
        check_eq("t4_up_done", {31'd0, bus.tile_on_o[4]},   32'd1);
        check_eq("t4_rst_n",   {31'd0, bus.tile_rst_no[4]}, 32'd1);
        step(1);
        check_eq("t4_dn_start", {31'd0, bus.iso_req_o[4]},  32'd1);
        bus.iso_ack_i = 16'h0010;
        wait_settle("t4", 100);
        bus.iso_ack_i = 16'h0000;

        // Tile 5 power-down with no ack
        set_cfg(cfg | 16'h0020);
        wait_settle("t5up", 100);
        set_cfg(cfg & ~16'h0020);
        step(1);
        check_eq("t5_iso_req", {31'd0, bus.iso_req_o[5]}, 32'd1);
`ifdef TILE_SEQ_TIMEOUT_EN
        step(1023);
        check_eq("t5_err_pre",   {31'd0, bus.err_o[5]},       32'd0);
        check_eq("t5_rst_pre",   {31'd0, bus.tile_rst_no[5]}, 32'd1);
        step(1);
        check_eq("t5_err_set",   {31'd0, bus.err_o[5]},       32'd1);
        check_eq("t5_rst_fall",  {31'd0, bus.tile_rst_no[5]}, 32'd0);
        step(7);
        check_eq("t5_clk_h7",    {31'd0, bus.tile_clk_en_o[5]}, 32'd1);
        step(1);
        check_eq("t5_clk_off",   {31'd0, bus.tile_clk_en_o[5]}, 32'd0);
        wait_settle("t5dn", 100);
        check_eq("t5_err_sticky", {16'd0, bus.err_o}, 32'h0020);
`else
        step(1033);
        check_eq("t5_busy_stuck", {31'd0, bus.busy_o},         32'd1);
        check_eq("t5_rst_held",   {31'd0, bus.tile_rst_no[5]}, 32'd1);
        check_eq("t5_err_zero",   {16'd0, bus.err_o},          32'h0000);
        bus.iso_ack_i = 16'h0020;
        wait_settle("t5dn", 100);
        bus.iso_ack_i = 16'h0000;
`endif

        // Async reset mid-UP_HOLD
        set_cfg(cfg | 16'h0040);
        step(4);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_clk_en",  {16'd0, bus.tile_clk_en_o}, 32'h0000);
        check_eq("mid_rst_rst_n",   {16'd0, bus.tile_rst_no},   32'h0000);
        check_eq("mid_rst_iso_req", {16'd0, bus.iso_req_o},     32'hFFFF);
        check_eq("mid_rst_tile_on", {16'd0, bus.tile_on_o},     32'h0000);
        check_eq("mid_rst_busy",    {31'd0, bus.busy_o},        32'd0);
        check_eq("mid_rst_err",     {16'd0, bus.err_o},         32'h0000);
        rst = 1'b0;
        step(1);
        check_eq("restart_t0", {16'd0, bus.tile_clk_en_o}, 32'h0001);
        wait_settle("restart", 200);

        // Test-mode override mid-sequence
        set_cfg(cfg | 16'h0100);
        step(2);
        bus.test_mode_i = 1'b1;
        #1;
        check_eq("tm_clk_en",  {16'd0, bus.tile_clk_en_o}, 32'hFFFF);
        check_eq("tm_rst_n",   {16'd0, bus.tile_rst_no},   32'hFFFF);
        check_eq("tm_iso_req", {16'd0, bus.iso_req_o},     32'h0000);
        bus.test_mode_i = 1'b0;
        #1;
        check_eq("tm_off_clk8", {31'd0, bus.tile_clk_en_o[8]}, 32'd1);
        check_eq("tm_off_rst8", {31'd0, bus.tile_rst_no[8]},   32'd0);
        wait_settle("tm", 100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
